sobel_window_ctrl: RTL and testbench

Stream-to-window sequencer for the `sobel` 3x3 edge datapath. It accepts a raster RGB pixel stream and keeps two line buffers plus a 3x3 window register. It presents the nine window taps to `sobel` and emits valid/SOF/EOL sideband delayed to line up with `sobel`'s `Dout`. It sits between the camera/DMA input stream and the `sobel` instance in the video pipeline.

---
 rtl/sobel_window_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_window_ctrl
//
// Turns a raster RGB pixel stream into the 3x3 window used by the sobel
// edge datapath. Two line buffers hold the previous two rows. A 3x3 tap
// register holds the current window. A sideband delay line re-times
// valid/SOF/EOL so that they line up with sobel's Dout.
//
// Parameters
//   WIDTH      active pixels per line (>= 3)
//   HEIGHT     active lines per frame (>= 3)
//   SOBEL_LAT  cycles from sobel window inputs to Dout (>= 1)
//
// Ports
//   CLK              single clock
//   RESET            asynchronous active-low reset
//   DIN[23:0]        pixel {R,G,B}
//   DIN_VALID        pixel qualifier; a pixel is accepted every cycle it is high
//   DIN_SOF          first pixel of frame (qualified by DIN_VALID)
//   DIN_EOL          last pixel of line (qualified by DIN_VALID)
//   D00..D22[23:0]   window taps; row 0 is oldest, column 0 is newest
//   OUT_VALID        sobel Dout carries a valid output pixel this cycle
//   OUT_SOF          first output pixel of the frame
//   OUT_EOL          last output pixel of the line
//   FRAME_DONE       one-cycle pulse when a frame completes cleanly
//   ERR              sticky framing error
//   ERR_CLR          clears ERR; a simultaneous new error wins
// ---------------------------------------------------------------------------
module sobel_window_ctrl #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int SOBEL_LAT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] DIN,
  input  logic        DIN_VALID,
  input  logic        DIN_SOF,
  input  logic        DIN_EOL,
  output logic [23:0] D00,
  output logic [23:0] D01,
  output logic [23:0] D02,
  output logic [23:0] D10,
  output logic [23:0] D11,
  output logic [23:0] D12,
  output logic [23:0] D20,
  output logic [23:0] D21,
  output logic [23:0] D22,
  output logic        OUT_VALID,
  output logic        OUT_SOF,
  output logic        OUT_EOL,
  output logic        FRAME_DONE,
  output logic        ERR,
  input  logic        ERR_CLR
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  localparam logic [0:0] ST_WAIT_SOF = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [0:0]    state_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;

  logic [0:0]    state_nxt_s;
  logic [CW-1:0] col_nxt_s;
  logic [RW-1:0] row_nxt_s;
  logic          accept_s;
  logic          restart_s;
  logic          err_s;
  logic          done_s;
  logic [CW-1:0] pos_c_s;
  logic [RW-1:0] pos_r_s;

  logic          win_valid_s;
  logic          win_sof_s;
  logic          win_eol_s;
  logic [2:0]    win_r;
  logic [2:0]    dly_r [SOBEL_LAT];

  // Line buffers are never cleared: rows 0-1 of every frame rewrite them
  // before any window that reads them is flagged valid.
  logic [23:0]   lb1_r [WIDTH];
  logic [23:0]   lb2_r [WIDTH];

  // Decode the incoming pixel: acceptance, raster position and framing outcome.
  always_comb begin
    accept_s    = 1'b0;
    restart_s   = 1'b0;
    err_s       = 1'b0;
    done_s      = 1'b0;
    pos_c_s     = col_r;
    pos_r_s     = row_r;
    state_nxt_s = state_r;
    col_nxt_s   = col_r;
    row_nxt_s   = row_r;

    case (state_r)
      ST_WAIT_SOF: accept_s = DIN_VALID & DIN_SOF;
      ST_RUN:      accept_s = DIN_VALID;
      default:     accept_s = 1'b0;
    endcase

    // A SOF pixel is always (0,0); seeing one mid-frame is a restart error.
    if (accept_s && DIN_SOF) begin
      pos_c_s   = '0;
      pos_r_s   = '0;
      restart_s = (state_r == ST_RUN) && ((col_r != '0) || (row_r != '0));
    end else begin
      pos_c_s   = col_r;
      pos_r_s   = row_r;
      restart_s = 1'b0;
    end

    if (accept_s) begin
      if (DIN_EOL && (pos_c_s != COL_LAST)) begin
        err_s       = 1'b1;
        col_nxt_s   = '0;
        row_nxt_s   = '0;
        state_nxt_s = ST_WAIT_SOF;
      end else if (!DIN_EOL && (pos_c_s == COL_LAST)) begin
        err_s       = 1'b1;
        col_nxt_s   = '0;
        row_nxt_s   = '0;
        state_nxt_s = ST_WAIT_SOF;
      end else if (DIN_EOL) begin
        if (pos_r_s == ROW_LAST) begin
          err_s       = restart_s;
          done_s      = 1'b1;
          col_nxt_s   = '0;
          row_nxt_s   = '0;
          state_nxt_s = ST_WAIT_SOF;
        end else begin
          err_s       = restart_s;
          col_nxt_s   = '0;
          row_nxt_s   = pos_r_s + RW'(1);
          state_nxt_s = ST_RUN;
        end
      end else begin
        err_s       = restart_s;
        col_nxt_s   = pos_c_s + CW'(1);
        row_nxt_s   = pos_r_s;
        state_nxt_s = ST_RUN;
      end
    end else begin
      err_s       = 1'b0;
      state_nxt_s = state_r;
    end
  end

  // Only interior windows (both row and column at least 2) reach the output.
  assign win_valid_s = accept_s && (pos_r_s >= ROW_TWO) && (pos_c_s >= COL_TWO);
  assign win_sof_s   = win_valid_s && (pos_r_s == ROW_TWO) && (pos_c_s == COL_TWO);
  assign win_eol_s   = win_valid_s && (pos_c_s == COL_LAST);

  // Frame state, raster counters, completion pulse and sticky error flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r    <= ST_WAIT_SOF;
      col_r      <= '0;
      row_r      <= '0;
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      col_r      <= col_nxt_s;
      row_r      <= row_nxt_s;
      FRAME_DONE <= done_s;
      if (err_s) begin
        ERR <= 1'b1;
      end else if (ERR_CLR) begin
        ERR <= 1'b0;
      end else begin
        ERR <= ERR;
      end
    end
  end

  // Sideband delay line; it free-runs like sobel, so bubbles shift through too.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      win_r <= 3'b000;
      for (int i = 0; i < SOBEL_LAT; i++) begin
        dly_r[i] <= 3'b000;
      end
    end else begin
      win_r    <= {win_valid_s, win_sof_s, win_eol_s};
      dly_r[0] <= win_r;
      for (int i = 1; i < SOBEL_LAT; i++) begin
        dly_r[i] <= dly_r[i-1];
      end
    end
  end

  assign OUT_VALID = dly_r[SOBEL_LAT-1][2];
  assign OUT_SOF   = dly_r[SOBEL_LAT-1][1];
  assign OUT_EOL   = dly_r[SOBEL_LAT-1][0];

  // Window taps: shift one column on each accepted pixel, hold otherwise.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      D00 <= 24'h000000;
      D01 <= 24'h000000;
      D02 <= 24'h000000;
      D10 <= 24'h000000;
      D11 <= 24'h000000;
      D12 <= 24'h000000;
      D20 <= 24'h000000;
      D21 <= 24'h000000;
      D22 <= 24'h000000;
    end else if (accept_s) begin
      D02 <= D01;
      D01 <= D00;
      D00 <= lb2_r[pos_c_s];
      D12 <= D11;
      D11 <= D10;
      D10 <= lb1_r[pos_c_s];
      D22 <= D21;
      D21 <= D20;
      D20 <= DIN;
    end
  end

  // Line buffers: the previous row ages into the older buffer as the new row lands.
  always_ff @(posedge CLK) begin
    if (accept_s) begin
      lb2_r[pos_c_s] <= lb1_r[pos_c_s];
      lb1_r[pos_c_s] <= DIN;
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
module tb_sobel_window_ctrl;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [23:0] DIN = 24'h0;
  logic        DIN_VALID = 1'b0, DIN_SOF = 1'b0, DIN_EOL = 1'b0, ERR_CLR = 1'b0;
  logic [23:0] D00, D01, D02, D10, D11, D12, D20, D21, D22;
  logic        OUT_VALID, OUT_SOF, OUT_EOL, FRAME_DONE, ERR;

  always #5 CLK = ~CLK;

  sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H), .SOBEL_LAT(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_SOF(DIN_SOF),
    .DIN_EOL(DIN_EOL), .D00(D00), .D01(D01), .D02(D02), .D10(D10), .D11(D11),
    .D12(D12), .D20(D20), .D21(D21), .D22(D22), .OUT_VALID(OUT_VALID),
    .OUT_SOF(OUT_SOF), .OUT_EOL(OUT_EOL), .FRAME_DONE(FRAME_DONE), .ERR(ERR),
    .ERR_CLR(ERR_CLR)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_bad = 0;

  // observed and expected sideband events: {cycle, valid, sof, eol}
  logic [34:0]  obs_q[$];
  logic [34:0]  exp_q[$];
  int           obs_done_q[$];
  int           exp_done_q[$];
  logic [215:0] tap_hist [int];
  logic [215:0] exp_tap_v[$];
  int           exp_tap_c[$];

  // reference model: frame image and stream position
  logic [23:0] img [H][W];
  bit m_inframe = 1'b0;
  bit m_err = 1'b0;
  int m_r = 0, m_c = 0;
  int t22 = 0, tlast = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    tap_hist[cyc] = {D00, D01, D02, D10, D11, D12, D20, D21, D22};
    if (OUT_VALID || OUT_SOF || OUT_EOL) obs_q.push_back({cyc, OUT_VALID, OUT_SOF, OUT_EOL});
    if (FRAME_DONE) obs_done_q.push_back(cyc);
    if (!RESET && ({D00, D01, D02, D10, D11, D12, D20, D21, D22} != '0 ||
                   OUT_VALID || OUT_SOF || OUT_EOL || FRAME_DONE || ERR)) rst_bad++;
  end

  // One cycle of stimulus; the model derives what the pixel must produce.
  task automatic drive(input bit v, input bit s, input bit e, input logic [23:0] d, input bit clr);
    int r, c;
    bit bad;
    logic [215:0] t;
    @(posedge CLK);
    #1;
    DIN_VALID = v; DIN_SOF = s; DIN_EOL = e; DIN = d; ERR_CLR = clr;
    bad = 1'b0;
    if (v && (m_inframe || s)) begin
      if (s) begin
        bad = m_inframe && (m_r != 0 || m_c != 0);
        r = 0; c = 0;
      end else begin
        r = m_r; c = m_c;
      end
      img[r][c] = d;
      if (r >= 2 && c >= 2) begin
        exp_q.push_back({32'(cyc + LAT + 1), 1'b1, 1'(r == 2 && c == 2), 1'(c == W - 1)});
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            t[(8 - (i * 3 + j)) * 24 +: 24] = img[r - 2 + i][c - j];
        exp_tap_v.push_back(t);
        exp_tap_c.push_back(cyc + 1);
      end
      if (e != (c == W - 1)) begin
        bad = 1'b1; m_inframe = 1'b0; m_r = 0; m_c = 0;
      end else if (e && r == H - 1) begin
        exp_done_q.push_back(cyc + 1); tlast = cyc;
        m_inframe = 1'b0; m_r = 0; m_c = 0;
      end else if (e) begin
        m_inframe = 1'b1; m_r = r + 1; m_c = 0;
      end else begin
        m_inframe = 1'b1; m_r = r; m_c = c + 1;
      end
    end
    if (bad) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  // Raster pixels from (0,0) up to, not including, (stop_r, stop_c).
  task automatic send_frame(input bit rnd, input bit toggle, input int stop_r, input int stop_c);
    logic [23:0] d;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        d = rnd ? 24'($urandom) : {8'(r), 8'(c), 8'h00};
        drive(1'b1, (r == 0 && c == 0), (c == W - 1), d, 1'b0);
        if (r == 2 && c == 2) t22 = cyc;
        if (toggle) idle(1);
      end
    end
  endtask

  task automatic flush();
    obs_q.delete(); exp_q.delete(); obs_done_q.delete(); exp_done_q.delete();
    exp_tap_v.delete(); exp_tap_c.delete(); tap_hist.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({D00, D01, D02, D10, D11, D12, D20, D21, D22, OUT_VALID, OUT_SOF, OUT_EOL, FRAME_DONE, ERR} !== '0) begin
      errors++;
      $display("FAIL reset_state: got taps=%h flags=%b required all zero",
               {D00, D01, D02, D10, D11, D12, D20, D21, D22}, {OUT_VALID, OUT_SOF, OUT_EOL, FRAME_DONE, ERR});
    end
    RESET = 1'b1;
    idle(2);
    checks++;
    if ({OUT_VALID, OUT_SOF, OUT_EOL, FRAME_DONE, ERR} !== 5'b0) begin
      errors++;
      $display("FAIL after_reset_flags: got %b required 00000", {OUT_VALID, OUT_SOF, OUT_EOL, FRAME_DONE, ERR});
    end
  endtask

  task automatic test_frame();
    logic [215:0] tv;
    flush();
    send_frame(1'b0, 1'b0, H, 0);
    idle(8);
    checks++;
    if (obs_q.size() != 24) begin errors++; $display("FAIL frame_out_count: got %0d required 24", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL frame_out[%0d]: got cyc=%0d vse=%b required cyc=%0d vse=%b", i, obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (obs_q.size() == 0 || obs_q[0] !== {32'(t22 + 5), 3'b110}) begin
      errors++; $display("FAIL frame_first_sof: got %h required cyc=%0d vse=110", obs_q.size() ? obs_q[0] : 35'h0, t22 + 5);
    end
    tv = tap_hist.exists(t22 + 1) ? tap_hist[t22 + 1] : 'x;
    checks++;
    if (tv[215:192] !== 24'h000200 || tv[23:0] !== 24'h020000) begin
      errors++; $display("FAIL frame_taps22: got D00=%h D22=%h required 000200 020000", tv[215:192], tv[23:0]);
    end
    for (int i = 0; i < exp_tap_c.size(); i++) begin
      tv = tap_hist.exists(exp_tap_c[i]) ? tap_hist[exp_tap_c[i]] : 'x;
      checks++;
      if (tv !== exp_tap_v[i]) begin errors++; $display("FAIL frame_taps[%0d]: got %h required %h", i, tv, exp_tap_v[i]); end
    end
    checks++;
    if (obs_done_q.size() != 1 || obs_done_q[0] != tlast + 1) begin
      errors++; $display("FAIL frame_done: got %0d pulses (first cyc %0d) required 1 at cyc %0d", obs_done_q.size(), obs_done_q.size() ? obs_done_q[0] : -1, tlast + 1);
    end
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL frame_err: got %b required 0", ERR); end
  endtask

  task automatic test_bubbles();
    logic [215:0] tv;
    flush();
    send_frame(1'b1, 1'b1, H, 0);
    idle(8);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bubble_out_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bubble_out[%0d]: got cyc=%0d vse=%b required cyc=%0d vse=%b", i, obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (obs_q.size() < 2 || obs_q[1][34:3] - obs_q[0][34:3] != 2) begin
      errors++; $display("FAIL bubble_spacing: got %0d outputs, first gap wrong, required gap 2", obs_q.size());
    end
    for (int i = 0; i < exp_tap_c.size(); i++) begin
      tv = tap_hist.exists(exp_tap_c[i]) ? tap_hist[exp_tap_c[i]] : 'x;
      checks++;
      if (tv !== exp_tap_v[i]) begin errors++; $display("FAIL bubble_taps[%0d]: got %h required %h", i, tv, exp_tap_v[i]); end
    end
    checks++;
    if (obs_done_q.size() != 1 || obs_done_q[0] != tlast + 1) begin
      errors++; $display("FAIL bubble_done: got %0d pulses required 1 at cyc %0d", obs_done_q.size(), tlast + 1);
    end
  endtask

  task automatic test_eol_err();
    int tclean, n;
    flush();
    send_frame(1'b1, 1'b0, 3, 5);
    drive(1'b1, 1'b0, 1'b1, 24'($urandom), 1'b0);
    idle(1);
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL eol_err_set: got ERR=%b required 1", ERR); end
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 24'($urandom), 1'b0);
    idle(3);
    tclean = cyc;
    send_frame(1'b1, 1'b0, H, 0);
    idle(8);
    n = 0;
    foreach (obs_q[i]) if (int'(obs_q[i][34:3]) > tclean && obs_q[i][2]) n++;
    checks++;
    if (n != 24) begin errors++; $display("FAIL eol_err_clean_count: got %0d required 24", n); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL eol_err_out_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL eol_err_out[%0d]: got cyc=%0d vse=%b required cyc=%0d vse=%b", i, obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (obs_done_q.size() != 1 || obs_done_q[0] != tlast + 1) begin
      errors++; $display("FAIL eol_err_done: got %0d pulses required 1 at cyc %0d", obs_done_q.size(), tlast + 1);
    end
    checks++;
    if (ERR !== m_err) begin errors++; $display("FAIL eol_err_sticky: got ERR=%b required %b", ERR, m_err); end
    drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
    idle(1);
    checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL err_clr: got ERR=%b required 0", ERR); end
  endtask

  task automatic test_sof_err();
    int nsof;
    flush();
    send_frame(1'b1, 1'b0, 4, 3);
    send_frame(1'b1, 1'b0, H, 0);
    idle(8);
    checks++;
    if (ERR !== 1'b1) begin errors++; $display("FAIL sof_err_set: got ERR=%b required 1", ERR); end
    nsof = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) nsof = i;
    checks++;
    if (obs_q.size() == 0 || obs_q[nsof] !== {32'(t22 + 5), 3'b110}) begin
      errors++; $display("FAIL sof_err_restart_sof: got %h required cyc=%0d vse=110", obs_q.size() ? obs_q[nsof] : 35'h0, t22 + 5);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL sof_err_out_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sof_err_out[%0d]: got cyc=%0d vse=%b required cyc=%0d vse=%b", i, obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (obs_done_q.size() != 1 || obs_done_q[0] != tlast + 1) begin
      errors++; $display("FAIL sof_err_done: got %0d pulses required 1 at cyc %0d", obs_done_q.size(), tlast + 1);
    end
    drive(1'b0, 1'b0, 1'b0, 24'h0, 1'b1);
    idle(1);
  endtask

  task automatic test_reset_mid();
    int cut;
    flush();
    rst_bad = 0;
    send_frame(1'b1, 1'b0, 3, 5);
    @(posedge CLK);
    #1;
    RESET = 1'b0; DIN_VALID = 1'b0; DIN_SOF = 1'b0; DIN_EOL = 1'b0;
    cut = cyc;
    for (int i = exp_q.size() - 1; i >= 0; i--) if (int'(exp_q[i][34:3]) >= cut) exp_q.delete(i);
    for (int i = exp_tap_c.size() - 1; i >= 0; i--) if (exp_tap_c[i] >= cut) begin exp_tap_c.delete(i); exp_tap_v.delete(i); end
    for (int i = exp_done_q.size() - 1; i >= 0; i--) if (exp_done_q[i] >= cut) exp_done_q.delete(i);
    m_inframe = 1'b0; m_r = 0; m_c = 0; m_err = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    send_frame(1'b1, 1'b0, H, 0);
    idle(8);
    checks++;
    if (rst_bad != 0) begin errors++; $display("FAIL reset_mid_outputs: got %0d nonzero samples in reset required 0", rst_bad); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_mid_out_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reset_mid_out[%0d]: got cyc=%0d vse=%b required cyc=%0d vse=%b", i, obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (obs_done_q.size() != 1 || obs_done_q[0] != tlast + 1) begin
      errors++; $display("FAIL reset_mid_done: got %0d pulses required 1 at cyc %0d", obs_done_q.size(), tlast + 1);
    end
  endtask

  task automatic test_back_to_back();
    int nsof;
    logic [215:0] tv;
    flush();
    send_frame(1'b1, 1'b0, H, 0);
    send_frame(1'b1, 1'b0, H, 0);
    idle(8);
    checks++;
    if (obs_q.size() != 48) begin errors++; $display("FAIL b2b_out_count: got %0d required 48", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got cyc=%0d vse=%b required cyc=%0d vse=%b", i, obs_q[i][34:3], obs_q[i][2:0], exp_q[i][34:3], exp_q[i][2:0]);
      end
    end
    nsof = 0;
    foreach (obs_q[i]) if (obs_q[i][1]) nsof++;
    checks++;
    if (nsof != 2) begin errors++; $display("FAIL b2b_sof_count: got %0d required 2", nsof); end
    for (int i = 0; i < exp_tap_c.size(); i++) begin
      tv = tap_hist.exists(exp_tap_c[i]) ? tap_hist[exp_tap_c[i]] : 'x;
      checks++;
      if (tv !== exp_tap_v[i]) begin errors++; $display("FAIL b2b_taps[%0d]: got %h required %h", i, tv, exp_tap_v[i]); end
    end
    checks++;
    if (obs_done_q.size() != 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", obs_done_q.size()); end
    for (int i = 0; i < exp_done_q.size() && i < obs_done_q.size(); i++) begin
      checks++;
      if (obs_done_q[i] != exp_done_q[i]) begin errors++; $display("FAIL b2b_done[%0d]: got cyc %0d required %0d", i, obs_done_q[i], exp_done_q[i]); end
    end
  endtask

  initial begin
    #2 RESET = 1'b0;
    test_reset();
    test_frame();
    test_bubbles();
    test_eol_err();
    test_sof_err();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
